// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader_pkg
// Description : Shared types and constants for the UART memory loader:
//               frame-parser state encoding, error codes, default sync byte.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_FLUSH  = 3'd5
    } loader_state_t;

    // Error codes reported on o_Err_Code
    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] c_ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'b11;

    // Frame start marker used when the instance does not override it
    localparam logic [7:0] c_DEFAULT_SYNC_BYTE = 8'hA5;

    // Byte address of the word following addr; wraps modulo 2^32
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_buffer
// Description : Single-entry ready/valid write holding register. Keeps the
//               address/data stable while the write is pending and flags an
//               overflow when a new word arrives before the old one drains.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_buffer
    import uart_loader_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Load,
    input  logic [31:0] i_Load_Addr,
    input  logic [31:0] i_Load_Data,
    input  logic        i_Drop,
    input  logic        i_Mem_Ready,
    output logic        o_Mem_We,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_Wdata,
    output logic        o_Overflow
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        w_accept;

    assign w_accept = r_valid && i_Mem_Ready;

    // A word that lands on a still-pending entry which is not draining this
    // cycle would overwrite unwritten data.
    assign o_Overflow = i_Load && r_valid && !i_Mem_Ready;

    // Holding register: drop beats load beats drain
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= RESET_ADDR;
            r_data  <= 32'd0;
        end else if (i_Drop) begin
            r_valid <= 1'b0;
        end else if (i_Load) begin
            r_valid <= 1'b1;
            r_addr  <= i_Load_Addr;
            r_data  <= i_Load_Data;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_Mem_We    = r_valid;
    assign o_Mem_Addr  = r_addr;
    assign o_Mem_Wdata = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_loader
// Description : Framed UART download parser. Decodes SYNC/LEN/DATA/CSUM
//               frames, packs little-endian 32-bit words and writes them to
//               memory through a ready/valid port; reports done or an error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE    = c_DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT_CLKS = 1000
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Mem_We,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_Wdata,
    input  logic        i_Mem_Ready,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code
);

    localparam int                 c_TMO_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CLKS);

    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [15:0]        r_len;
    logic [15:0]        r_word_cnt;
    logic [7:0]         r_xor;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word_sr;
    logic [31:0]        r_addr;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_start;
    logic               w_word_done;
    logic               w_timed_state;
    logic               w_timeout;
    logic               w_overflow;
    logic               w_buf_valid;
    logic               w_err_set;
    logic [1:0]         w_err_code;
    logic               w_done_set;
    logic [15:0]        w_len_full;

    // The three earlier bytes of a word sit in r_word_sr, oldest lowest
    assign w_word_done   = (r_state == ST_DATA) && i_Rx_DV && (r_byte_idx == 2'd3);
    assign w_timed_state = r_state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    assign w_timeout     = w_timed_state && !i_Rx_DV && (r_tmo_cnt == c_TMO_MAX);
    assign w_len_full    = {i_Rx_Byte, r_len[7:0]};
    assign w_buf_valid   = o_Mem_We;

    uart_word_buffer #(
        .RESET_ADDR (BASE_ADDR)
    ) u_word_buffer (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Load      (w_word_done),
        .i_Load_Addr (r_addr),
        .i_Load_Data ({i_Rx_Byte, r_word_sr}),
        .i_Drop      (w_err_set),
        .i_Mem_Ready (i_Mem_Ready),
        .o_Mem_We    (o_Mem_We),
        .o_Mem_Addr  (o_Mem_Addr),
        .o_Mem_Wdata (o_Mem_Wdata),
        .o_Overflow  (w_overflow)
    );

    // State register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, error detection and completion decode
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = c_ERR_NONE;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    w_start      = 1'b1;
                    w_next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (i_Rx_DV) begin
                    w_next_state = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (i_Rx_DV) begin
                    w_next_state = (w_len_full == 16'd0) ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_done) begin
                    if (w_overflow) begin
                        w_err_set    = 1'b1;
                        w_err_code   = c_ERR_OVERFLOW;
                        w_next_state = ST_IDLE;
                    end else if ((r_word_cnt + 16'd1) == r_len) begin
                        w_next_state = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != r_xor) begin
                        w_err_set    = 1'b1;
                        w_err_code   = c_ERR_CHECKSUM;
                        w_next_state = ST_IDLE;
                    end else if (!w_buf_valid || i_Mem_Ready) begin
                        // Buffer is empty or drains on this very edge
                        w_done_set   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!w_buf_valid || i_Mem_Ready) begin
                    w_done_set   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // Expiry only happens on a byte-free cycle, so it never collides
        // with the byte-driven decisions above.
        if (w_timeout) begin
            w_err_set    = 1'b1;
            w_err_code   = c_ERR_TIMEOUT;
            w_next_state = ST_IDLE;
        end
    end

    // Inter-byte idle counter, saturating at the limit
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_timed_state || i_Rx_DV) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != c_TMO_MAX) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    // Frame datapath: length, running XOR, word assembly, address, status
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_xor      <= 8'd0;
            r_byte_idx <= 2'd0;
            r_word_sr  <= 24'd0;
            r_addr     <= BASE_ADDR;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
        end else begin
            r_done <= w_done_set;
            if (w_start) begin
                r_len      <= 16'd0;
                r_word_cnt <= 16'd0;
                r_xor      <= 8'd0;
                r_byte_idx <= 2'd0;
                r_addr     <= BASE_ADDR;
                r_err      <= 1'b0;
                r_err_code <= c_ERR_NONE;
            end else if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end else if (i_Rx_DV) begin
                case (r_state)
                    ST_LEN_LO: begin
                        r_len[7:0] <= i_Rx_Byte;
                        r_xor      <= r_xor ^ i_Rx_Byte;
                    end
                    ST_LEN_HI: begin
                        r_len[15:8] <= i_Rx_Byte;
                        r_xor       <= r_xor ^ i_Rx_Byte;
                    end
                    ST_DATA: begin
                        r_xor      <= r_xor ^ i_Rx_Byte;
                        r_word_sr  <= {i_Rx_Byte, r_word_sr[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_addr     <= next_word_addr(r_addr);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_Busy     = (r_state != ST_IDLE);
    assign o_Done     = r_done;
    assign o_Err      = r_err;
    assign o_Err_Code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_loader
// Description : Self-checking bench for uart_mem_loader: directed frames,
//               backpressure, overflow, timeout, reset and random frames
//               checked against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          TMO  = 1000;

    logic        i_Clock = 1'b0;
    logic        i_Rst_n;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_Wdata;
    logic        i_Mem_Ready;
    logic        o_Busy;
    logic        o_Done;
    logic        o_Err;
    logic [1:0]  o_Err_Code;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_w[$];
    logic [7:0]  fr_q[$];
    int          done_cnt  = 0;
    int          stab_viol = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_data = 32'd0;

    always #5 i_Clock = ~i_Clock;

    uart_mem_loader #(
        .BASE_ADDR    (BASE),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Mem_We    (o_Mem_We),
        .o_Mem_Addr  (o_Mem_Addr),
        .o_Mem_Wdata (o_Mem_Wdata),
        .i_Mem_Ready (i_Mem_Ready),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Err       (o_Err),
        .o_Err_Code  (o_Err_Code)
    );

    // Memory-side monitor: accepted writes, done pulses, held-data stability
    always @(posedge i_Clock) begin
        if (o_Mem_We && i_Mem_Ready) wr_q.push_back({o_Mem_Addr, o_Mem_Wdata});
        if (o_Done) done_cnt <= done_cnt + 1;
        if (prev_pend && o_Mem_We && ((o_Mem_Addr !== prev_addr) || (o_Mem_Wdata !== prev_data)))
            stab_viol <= stab_viol + 1;
        prev_pend <= o_Mem_We && !i_Mem_Ready;
        prev_addr <= o_Mem_Addr;
        prev_data <= o_Mem_Wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_Rx_Byte = b;
        i_Rx_DV   = 1'b1;
        @(posedge i_Clock); #1;
        i_Rx_DV   = 1'b0;
        repeat (gap) begin @(posedge i_Clock); #1; end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < fr_q.size(); i++)
            send_byte(fr_q[i], (i == fr_q.size() - 1) ? 0 : gap);
    endtask

    // Reference model: frame bytes and expected writes from random words
    task automatic make_frame(input int len, input bit bad);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] l16;
        l16 = 16'(len);
        fr_q.delete();
        exp_w.delete();
        fr_q.push_back(8'hA5);
        fr_q.push_back(l16[7:0]);
        fr_q.push_back(l16[15:8]);
        cs = l16[7:0] ^ l16[15:8];
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            exp_w.push_back({BASE + 32'(4 * i), w});
            for (int k = 0; k < 4; k++) begin
                fr_q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        fr_q.push_back(bad ? ~cs : cs);
    endtask

    task automatic check_writes(input int start, input string tag);
        chk({tag, "_count"}, 64'(wr_q.size() - start), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            if (start + i < wr_q.size())
                chk($sformatf("%s_w%0d", tag, i), wr_q[start + i], exp_w[i]);
    endtask

    task automatic load_fixed_frame();
        fr_q  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        exp_w = '{64'h0000_0000_1234_5678, 64'h0000_0004_DEAD_BEEF};
    endtask

    initial begin
        int s;
        int d;
        int sv;
        int len;
        bit bad;
        int gap;

        i_Rst_n     = 1'b0;
        i_Rx_DV     = 1'b0;
        i_Rx_Byte   = 8'h00;
        i_Mem_Ready = 1'b1;
        repeat (3) begin @(posedge i_Clock); #1; end

        // Reset values
        chk("rst_we",    o_Mem_We,    0);
        chk("rst_addr",  o_Mem_Addr,  BASE);
        chk("rst_wdata", o_Mem_Wdata, 0);
        chk("rst_busy",  o_Busy,      0);
        chk("rst_done",  o_Done,      0);
        chk("rst_err",   o_Err,       0);
        chk("rst_code",  o_Err_Code,  0);
        i_Rst_n = 1'b1;
        repeat (2) begin @(posedge i_Clock); #1; end

        // Known good frame
        load_fixed_frame();
        s = wr_q.size(); d = done_cnt;
        send_frame(1);
        chk("good_done", o_Done, 1);
        chk("good_err",  o_Err,  0);
        chk("good_busy", o_Busy, 0);
        repeat (3) begin @(posedge i_Clock); #1; end
        check_writes(s, "good");
        chk("good_done_cnt", 64'(done_cnt - d), 1);

        // Same frame with a bad checksum byte
        load_fixed_frame();
        fr_q[11] = 8'h29;
        s = wr_q.size(); d = done_cnt;
        send_frame(1);
        chk("csum_err",  o_Err,      1);
        chk("csum_code", o_Err_Code, 2'b10);
        chk("csum_busy", o_Busy,     0);
        chk("csum_done", o_Done,     0);
        repeat (3) begin @(posedge i_Clock); #1; end
        check_writes(s, "csum");
        chk("csum_done_cnt", 64'(done_cnt - d), 0);

        // Next good frame clears the sticky error at SYNC
        load_fixed_frame();
        s = wr_q.size();
        send_byte(fr_q[0], 0);
        chk("clr_err",  o_Err,      0);
        chk("clr_code", o_Err_Code, 0);
        chk("clr_busy", o_Busy,     1);
        for (int i = 1; i < fr_q.size(); i++)
            send_byte(fr_q[i], (i == fr_q.size() - 1) ? 0 : 1);
        chk("clr_done", o_Done, 1);
        repeat (3) begin @(posedge i_Clock); #1; end
        check_writes(s, "clr");

        // Backpressure: memory stalls 30 clocks per word, bytes every 50
        make_frame(2, 1'b0);
        s = wr_q.size(); sv = stab_viol;
        for (int i = 0; i < fr_q.size(); i++) begin
            bit wend;
            wend = (i >= 3) && (i < fr_q.size() - 1) && (((i - 3) % 4) == 3);
            if (wend) i_Mem_Ready = 1'b0;
            send_byte(fr_q[i], 0);
            if (i != fr_q.size() - 1) begin
                if (wend) begin
                    repeat (29) begin @(posedge i_Clock); #1; end
                    chk($sformatf("bp_we_%0d", i), o_Mem_We, 1);
                    chk($sformatf("bp_addr_%0d", i), o_Mem_Addr, exp_w[(i - 3) / 4][63:32]);
                    chk($sformatf("bp_data_%0d", i), o_Mem_Wdata, exp_w[(i - 3) / 4][31:0]);
                    i_Mem_Ready = 1'b1;
                    repeat (20) begin @(posedge i_Clock); #1; end
                end else begin
                    repeat (49) begin @(posedge i_Clock); #1; end
                end
            end
        end
        chk("bp_done", o_Done, 1);
        chk("bp_err",  o_Err,  0);
        repeat (3) begin @(posedge i_Clock); #1; end
        check_writes(s, "bp");
        chk("bp_stable", 64'(stab_viol - sv), 0);

        // Overflow: first word never drains before the second completes
        make_frame(2, 1'b0);
        s = wr_q.size();
        i_Mem_Ready = 1'b1;
        for (int i = 0; i < fr_q.size() - 1; i++) begin
            if (i == 6) i_Mem_Ready = 1'b0;
            send_byte(fr_q[i], (i == fr_q.size() - 2) ? 0 : 1);
        end
        chk("ovf_err",  o_Err,      1);
        chk("ovf_code", o_Err_Code, 2'b11);
        chk("ovf_busy", o_Busy,     0);
        chk("ovf_we",   o_Mem_We,   0);
        i_Mem_Ready = 1'b1;
        repeat (3) begin @(posedge i_Clock); #1; end
        chk("ovf_nowrite", 64'(wr_q.size() - s), 0);

        // Timeout after LEN_HI
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 0);
        repeat (TMO) begin @(posedge i_Clock); #1; end
        chk("tmo_early_err",  o_Err,  0);
        chk("tmo_early_busy", o_Busy, 1);
        @(posedge i_Clock); #1;
        chk("tmo_err",  o_Err,      1);
        chk("tmo_code", o_Err_Code, 2'b01);
        chk("tmo_busy", o_Busy,     0);

        // Garbage ignored, then an empty frame
        s = wr_q.size(); d = done_cnt;
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 1);
        chk("garb_busy", o_Busy, 0);
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        chk("len0_done", o_Done, 1);
        chk("len0_err",  o_Err,  0);
        repeat (3) begin @(posedge i_Clock); #1; end
        chk("len0_nowrite", 64'(wr_q.size() - s), 0);
        chk("len0_done_cnt", 64'(done_cnt - d), 1);

        // Asynchronous reset in the middle of DATA with a write pending
        make_frame(2, 1'b0);
        i_Mem_Ready = 1'b0;
        s = wr_q.size();
        for (int i = 0; i < 8; i++) send_byte(fr_q[i], 1);
        chk("mid_we_pending", o_Mem_We, 1);
        #3;
        i_Rst_n = 1'b0;
        #1;
        chk("arst_we",   o_Mem_We,    0);
        chk("arst_busy", o_Busy,      0);
        chk("arst_addr", o_Mem_Addr,  BASE);
        chk("arst_data", o_Mem_Wdata, 0);
        @(posedge i_Clock); #1;
        i_Rst_n     = 1'b1;
        i_Mem_Ready = 1'b1;
        @(posedge i_Clock); #1;
        load_fixed_frame();
        send_frame(1);
        chk("post_rst_done", o_Done, 1);
        repeat (3) begin @(posedge i_Clock); #1; end
        check_writes(s, "post_rst");

        // Random frames against the model
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(0, 5);
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 3);
            make_frame(len, bad);
            s = wr_q.size(); d = done_cnt;
            send_frame(gap);
            chk($sformatf("rnd%0d_done", r), o_Done,     bad ? 0 : 1);
            chk($sformatf("rnd%0d_err", r),  o_Err,      bad ? 1 : 0);
            chk($sformatf("rnd%0d_code", r), o_Err_Code, bad ? 2'b10 : 2'b00);
            repeat (3) begin @(posedge i_Clock); #1; end
            check_writes(s, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_done_cnt", r), 64'(done_cnt - d), bad ? 0 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
